// File: rtl/zeroheti_pkg.sv
// zeroheti_pkg: shared types and defaults for the zeroheti OBI arbiter
package zeroheti_pkg;
  typedef enum logic {ARB_IDLE, ARB_WAIT_RSP} arb_state_e;
  localparam int DefaultArbNumReq = 3;
endpackage

// File: rtl/zeroheti_obi_arbiter_if.sv
// zeroheti_obi_arbiter_if: requester-side and subordinate-side OBI signals of the arbiter
interface zeroheti_obi_arbiter_if #(
  parameter int NumReq    = 3,
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32
);
  logic [NumReq-1:0]                  req_i;
  logic [NumReq-1:0][AddrWidth-1:0]   addr_i;
  logic [NumReq-1:0]                  we_i;
  logic [NumReq-1:0][DataWidth/8-1:0] be_i;
  logic [NumReq-1:0][DataWidth-1:0]   wdata_i;
  logic [NumReq-1:0]                  gnt_o;
  logic [NumReq-1:0]                  rvalid_o;
  logic [DataWidth-1:0]               rdata_o;
  logic                               err_o;
  logic                               req_o;
  logic [AddrWidth-1:0]               addr_o;
  logic                               we_o;
  logic [DataWidth/8-1:0]             be_o;
  logic [DataWidth-1:0]               wdata_o;
  logic                               gnt_i;
  logic                               rvalid_i;
  logic [DataWidth-1:0]               rdata_i;
  logic                               err_i;
  modport slave (
    input  req_i, addr_i, we_i, be_i, wdata_i, gnt_i, rvalid_i, rdata_i, err_i,
    output gnt_o, rvalid_o, rdata_o, err_o, req_o, addr_o, we_o, be_o, wdata_o
  );
  modport master (
    output req_i, addr_i, we_i, be_i, wdata_i, gnt_i, rvalid_i, rdata_i, err_i,
    input  gnt_o, rvalid_o, rdata_o, err_o, req_o, addr_o, we_o, be_o, wdata_o
  );
endinterface

// File: rtl/zeroheti_rr_select.sv
// zeroheti_rr_select: first requester found searching from ptr upward, wrapping modulo NumReq
module zeroheti_rr_select import zeroheti_pkg::*; #(
  parameter int  NumReq = DefaultArbNumReq,
  localparam int IdxW   = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] req,
  input  logic [IdxW-1:0]   ptr,
  output logic [NumReq-1:0] onehot,
  output logic [IdxW-1:0]   idx,
  output logic              valid
);
  logic [IdxW-1:0] j;
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    j     = '0;
    // walk offsets from far to near so the nearest requester is the last write
    for (int k = NumReq - 1; k >= 0; k--) begin
      j = IdxW'((int'(ptr) + k) % NumReq);
      if (req[j]) begin
        idx   = j;
        valid = 1'b1;
      end
    end
    onehot = valid ? NumReq'(1) << idx : '0;
  end
endmodule

// File: rtl/zeroheti_obi_arbiter.sv
// zeroheti_obi_arbiter: N-to-1 OBI arbiter, one outstanding transaction, winner lock until grant.
// ZEROHETI_ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module zeroheti_obi_arbiter import zeroheti_pkg::*; #(
  parameter int NumReq    = DefaultArbNumReq,
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  zeroheti_obi_arbiter_if.slave  bus,
  output logic                   busy_o,
  output logic                   spurious_o
);
  localparam int IdxW = $clog2(NumReq);
  arb_state_e        state_q, state_d;
  logic [IdxW-1:0]   owner_q, lock_idx_q, sel_idx, w, ptr;
  logic [NumReq-1:0] sel_oh, w_oh;
  logic              lock_q, lock_hit, sel_valid, idle, hs;
  zeroheti_rr_select #(.NumReq(NumReq)) u_select (
    .req    (bus.req_i),
    .ptr    (ptr),
    .onehot (sel_oh),
    .idx    (sel_idx),
    .valid  (sel_valid)
  );
  // a locked winner that drops its request loses the lock and normal selection applies
  assign lock_hit = lock_q && bus.req_i[lock_idx_q];
  assign w        = lock_hit ? lock_idx_q : sel_idx;
  assign w_oh     = lock_hit ? NumReq'(1) << lock_idx_q : sel_oh;
  assign idle     = rst_ni && state_q == ARB_IDLE;
  assign hs       = idle && sel_valid && bus.gnt_i;
  assign busy_o      = state_q == ARB_WAIT_RSP;
  assign spurious_o  = idle && bus.rvalid_i;
  assign bus.addr_o  = bus.addr_i[w];
  assign bus.we_o    = bus.we_i[w];
  assign bus.be_o    = bus.be_i[w];
  assign bus.wdata_o = bus.wdata_i[w];
  assign bus.rdata_o = bus.rdata_i;
  assign bus.err_o   = bus.err_i;
  always_comb begin
    state_d      = state_q;
    bus.req_o    = 1'b0;
    bus.gnt_o    = '0;
    bus.rvalid_o = '0;
    if (idle) begin
      bus.req_o = sel_valid;
      bus.gnt_o = hs ? w_oh : '0;
      state_d   = hs ? ARB_WAIT_RSP : ARB_IDLE;
    end else if (state_q == ARB_WAIT_RSP) begin
      bus.rvalid_o = bus.rvalid_i ? NumReq'(1) << owner_q : '0;
      state_d      = bus.rvalid_i ? ARB_IDLE : ARB_WAIT_RSP;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ARB_IDLE;
      owner_q    <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      state_q <= state_d;
      lock_q  <= idle && sel_valid && !bus.gnt_i;
      if (hs) owner_q <= w;
      if (idle && sel_valid && !bus.gnt_i) lock_idx_q <= w;
    end
  end
`ifdef ZEROHETI_ARB_FIXED_PRIO_EN
  assign ptr = '0;
`else
  logic [IdxW-1:0] p_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) p_q <= '0;
    else if (hs) p_q <= (w == IdxW'(NumReq - 1)) ? '0 : w + 1'b1;
  end
  assign ptr = p_q;
`endif
endmodule
